// File: rtl/qam_mapper.sv
// qam_mapper: groups N_BPSC serial interleaved bits per subcarrier and
// Gray-maps them to un-normalised BPSK/QPSK/16-QAM/64-QAM I/Q levels,
// flagging the last data subcarrier of each OFDM symbol.
module qam_mapper #(
    parameter int N_SD  = 48,
    parameter int OUT_W = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEN,
    input  logic             iRateEN,
    input  logic [3:0]       iRate,
    input  logic             iData,
    input  logic             iValid,
    output logic [OUT_W-1:0] oI,
    output logic [OUT_W-1:0] oQ,
    output logic             oValid,
    output logic             oLast,
    output logic             oRateErr
);

    localparam int SC_W = (N_SD > 1) ? $clog2(N_SD) : 1;

    localparam logic [1:0] MOD_BPSK  = 2'd0;
    localparam logic [1:0] MOD_QPSK  = 2'd1;
    localparam logic [1:0] MOD_QAM16 = 2'd2;
    localparam logic [1:0] MOD_QAM64 = 2'd3;

    logic [1:0]       mod_q;
    logic [2:0]       bit_cnt;
    logic [SC_W-1:0]  sc_cnt;
    logic [5:0]       shreg;

    logic             rate_load;
    logic             dec_ok;
    logic [1:0]       dec_mod;
    logic [1:0]       mod_eff;
    logic [2:0]       nbpsc_m1;
    logic             take;
    logic             grp_done;
    logic [5:0]       bits;
    logic [OUT_W-1:0] map_i;
    logic [OUT_W-1:0] map_q;

    // Apply sign: positive when the leading bit of the Gray field is 1.
    function automatic logic [OUT_W-1:0] lvl(input logic pos, input logic [OUT_W-1:0] mag);
        return pos ? mag : ('0 - mag);
    endfunction

    // 16-QAM magnitude from the second bit of a Gray pair.
    function automatic logic [OUT_W-1:0] mag16(input logic b);
        return b ? OUT_W'(1) : OUT_W'(3);
    endfunction

    // 64-QAM magnitude from the last two bits of a Gray triple.
    function automatic logic [OUT_W-1:0] mag64(input logic b, input logic c);
        logic [OUT_W-1:0] m;
        case ({b, c})
            2'b00:   m = OUT_W'(7);
            2'b01:   m = OUT_W'(5);
            2'b11:   m = OUT_W'(3);
            default: m = OUT_W'(1);
        endcase
        return m;
    endfunction

    // Rate decode; a load is only honoured between subcarrier groups at symbol start.
    always_comb begin
        dec_ok  = 1'b1;
        dec_mod = MOD_BPSK;
        case (iRate)
            4'b1101, 4'b1111: dec_mod = MOD_BPSK;
            4'b0101, 4'b0111: dec_mod = MOD_QPSK;
            4'b1001, 4'b1011: dec_mod = MOD_QAM16;
            4'b0001, 4'b0011: dec_mod = MOD_QAM64;
            default:          dec_ok  = 1'b0;
        endcase
        rate_load = iRateEN && (bit_cnt == 3'd0) && (sc_cnt == '0);
        // A rate strobed alongside the first bit governs that bit's group.
        mod_eff   = (rate_load && dec_ok) ? dec_mod : mod_q;
    end

    // Group length, bit capture and Gray mapping of the completed group.
    always_comb begin
        case (mod_eff)
            MOD_QPSK:  nbpsc_m1 = 3'd1;
            MOD_QAM16: nbpsc_m1 = 3'd3;
            MOD_QAM64: nbpsc_m1 = 3'd5;
            default:   nbpsc_m1 = 3'd0;
        endcase
        take          = iEN && iValid;
        grp_done      = take && (bit_cnt == nbpsc_m1);
        bits          = shreg;
        bits[bit_cnt] = iData;
        map_i         = '0;
        map_q         = '0;
        case (mod_eff)
            MOD_QPSK: begin
                map_i = lvl(bits[0], OUT_W'(1));
                map_q = lvl(bits[1], OUT_W'(1));
            end
            MOD_QAM16: begin
                map_i = lvl(bits[0], mag16(bits[1]));
                map_q = lvl(bits[2], mag16(bits[3]));
            end
            MOD_QAM64: begin
                map_i = lvl(bits[0], mag64(bits[1], bits[2]));
                map_q = lvl(bits[3], mag64(bits[4], bits[5]));
            end
            default: begin
                map_i = lvl(bits[0], OUT_W'(1));
                map_q = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            mod_q    <= MOD_BPSK;
            bit_cnt  <= '0;
            sc_cnt   <= '0;
            shreg    <= '0;
            oI       <= '0;
            oQ       <= '0;
            oValid   <= 1'b0;
            oLast    <= 1'b0;
            oRateErr <= 1'b0;
        end else begin
            oValid   <= grp_done;
            oLast    <= grp_done && (sc_cnt == SC_W'(N_SD - 1));
            oRateErr <= rate_load && !dec_ok;
            if (rate_load && dec_ok)
                mod_q <= dec_mod;
            if (!iEN) begin
                bit_cnt <= '0;
                sc_cnt  <= '0;
                shreg   <= '0;
            end else if (take) begin
                if (grp_done) begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                    oI      <= map_i;
                    oQ      <= map_q;
                    sc_cnt  <= (sc_cnt == SC_W'(N_SD - 1)) ? '0 : sc_cnt + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    shreg   <= bits;
                end
            end
        end
    end

endmodule

// File: doc/qam_mapper.md
Name: qam_mapper

Overview:
- Consumes the serial bit stream produced by the interleaver (its oData/oValid) and sits directly downstream of it in the 802.11a TX chain.
- Groups N_BPSC consecutive bits per subcarrier and Gray-maps them to BPSK/QPSK/16-QAM/64-QAM integer I/Q levels.
- Output levels are un-normalised; K_MOD scaling is applied downstream.
- Counts subcarriers per OFDM symbol and flags the 48th data subcarrier.

Parameters:
N_SD, 48, data subcarriers per OFDM symbol
OUT_W, 4, width of signed I/Q outputs (two's complement)

Ports:
iClk  in  1  clock, rising edge
iRst  in  1  asynchronous, active-low reset
iEN  in  1  block enable; low clears all bit and subcarrier counters
iRateEN  in  1  one-cycle strobe that loads iRate
iRate  in  4  802.11a RATE field R1..R4
iData  in  1  serial interleaved bit
iValid  in  1  iData qualifier (driven by the interleaver oValid)
oI  out  OUT_W  in-phase level
oQ  out  OUT_W  quadrature level
oValid  out  1  one-cycle pulse when oI/oQ hold a new symbol
oLast  out  1  high together with oValid on subcarrier N_SD-1
oRateErr  out  1  one-cycle pulse when a rejected iRate is strobed

Behaviour:
- Reset (iRst=0, asynchronous): oI=0, oQ=0, oValid=0, oLast=0, oRateErr=0, bit counter=0, subcarrier counter=0, shift register=0, modulation=BPSK.
- Rate decode on iRateEN:
  - 1101 and 1111 -> BPSK, N_BPSC=1.
  - 0101 and 0111 -> QPSK, N_BPSC=2.
  - 1001 and 1011 -> 16-QAM, N_BPSC=4.
  - 0001 and 0011 -> 64-QAM, N_BPSC=6.
  - Any other code: modulation register unchanged, oRateErr=1 on the next cycle.
- iRateEN is accepted only when the bit counter and subcarrier counter are both 0. Otherwise it is ignored, with no error pulse.
- Bit collection:
  - Each cycle with iEN=1 and iValid=1 shifts iData in. The first bit received is b0.
  - The bit counter increments on each such cycle; iValid=0 holds all state.
  - When the bit counter is N_BPSC-1 and a valid bit arrives:
    - The symbol is mapped.
    - The bit counter wraps to 0.
    - On the next rising edge, oValid=1 and oI/oQ are updated.
  - Latency is one cycle from the last bit of a group to oValid.
  - oI/oQ hold their value between pulses.
- Mapping (b0 is the first bit received):
  - BPSK: b0=0 -> I=-1, b0=1 -> I=+1; Q=0.
  - QPSK: I from b0, Q from b1; bit 0 -> -1, bit 1 -> +1.
  - 16-QAM: I from b0b1, Q from b2b3; 00->-3, 01->-1, 11->+1, 10->+3.
  - 64-QAM: I from b0b1b2, Q from b3b4b5; 000->-7, 001->-5, 011->-3, 010->-1, 110->+1, 111->+3, 101->+5, 100->+7.
- Subcarrier counter:
  - Increments on every emitted symbol.
  - At N_SD-1 it wraps to 0 and oLast=1 for that same oValid pulse.
- iEN=0 mid-group: partial bits are discarded, the bit counter and subcarrier counter are cleared, and no symbol is emitted. The modulation register is retained.
- Simultaneous iRateEN and a valid bit while idle: the rate is loaded first, and the bit is collected under the new N_BPSC.
- Reset asserted mid-symbol: immediate clear to reset values; any pending oValid is suppressed.

Test Plan:
- Rate 1101 (BPSK), bits 1,0 -> two oValid pulses: (I,Q)=(+1,0), then (-1,0); each pulse one cycle after its bit.
- Rate 0101 (QPSK), bits 0,1 -> one pulse (I,Q)=(-1,+1); no oValid after the first bit.
- Rate 1001 (16-QAM), bits 1,0,0,1 -> (I,Q)=(+3,-1). Rate 0001 (64-QAM), bits 1,0,1,0,1,1 -> (I,Q)=(+5,-3), with oI=4'b0101 and oQ=4'b1101.
- BPSK stream of 48 bits with iValid gaps of 2 cycles -> exactly 48 pulses; oLast=1 only on the 48th pulse; the 49th bit's pulse has oLast=0.
- 16-QAM: send 2 bits, drop iEN for 1 cycle, re-enable, send 1,1,1,1 -> single output (+1,+1). Separately, strobe iRate=0000 -> oRateErr pulse with modulation unchanged; strobe 0101 mid-group -> ignored.
- Assert iRst low asynchronously between clock edges mid-64-QAM group -> all outputs 0 immediately. After release, a 64-QAM group maps correctly only once iRateEN is re-applied, since the modulation defaults to BPSK after reset.
